// File: rtl/rtc_bus_scheduler.sv
// Arbiter for the shared RTC A/D bus: periodic read refresh, on-demand writes, idle gap after each access.
// Optional engine timeout is compiled in with `define RTC_SCHED_TIMEOUT_EN.
module rtc_bus_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,        // active low, asynchronous
  input  logic       wr_req_i,
  input  logic       lect_fin_i,
  input  logic [4:0] lect_bus_i,
  input  logic       esc_fin_i,
  input  logic [4:0] esc_bus_i,
  output logic       lect_start_o,
  output logic       esc_start_o,
  output logic [4:0] rtc_bus_o,
  output logic       rd_valid_o,
  output logic       wr_ack_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [2:0] state_o
);

  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    BUS_IDLE = 5'b11110;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_START = 3'd1,
    RD_BUSY  = 3'd2,
    WR_START = 3'd3,
    WR_BUSY  = 3'd4,
    GAP      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wr_pend_q, wr_pend_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_ack_q, wr_ack_d;
  logic          to_err_q, to_err_d;
  logic          wrap;
  logic          to_hit;

  assign wrap = (ref_q == REF_LAST);

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_q, to_d;

  // Holds (busy cycles so far - 1); zero outside BUSY so every entry starts fresh.
  always_comb begin
    to_d = '0;
    if (state_q == RD_BUSY || state_q == WR_BUSY) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) to_q <= '0;
    else          to_q <= to_d;
  end

  assign to_hit = (to_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ref_d        = wrap ? '0 : ref_q + 1'b1;
    gap_d        = gap_q;
    wr_pend_d    = wr_pend_q;
    rd_pend_d    = rd_pend_q;
    rd_valid_d   = 1'b0;
    wr_ack_d     = 1'b0;
    to_err_d     = 1'b0;
    rtc_bus_o    = BUS_IDLE;
    lect_start_o = 1'b0;
    esc_start_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend_q)      state_d = WR_START;
        else if (rd_pend_q) state_d = RD_START;
      end
      WR_START: begin
        esc_start_o = 1'b1;
        rtc_bus_o   = esc_bus_i;
        wr_pend_d   = 1'b0;
        state_d     = WR_BUSY;
      end
      RD_START: begin
        lect_start_o = 1'b1;
        rtc_bus_o    = lect_bus_i;
        rd_pend_d    = 1'b0;
        state_d      = RD_BUSY;
      end
      WR_BUSY: begin
        rtc_bus_o = esc_bus_i;
        if (esc_fin_i) begin
          wr_ack_d = 1'b1;
          state_d  = GAP;
        end else if (to_hit) begin
          to_err_d = 1'b1;
          state_d  = GAP;
        end
      end
      RD_BUSY: begin
        rtc_bus_o = lect_bus_i;
        if (lect_fin_i) begin
          rd_valid_d = 1'b1;
          state_d    = GAP;
        end else if (to_hit) begin
          to_err_d = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        // gap_q rests at zero outside GAP, so entry needs no explicit load.
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // New events override the clear issued by a START state in the same cycle.
    if (wr_req_i) wr_pend_d = 1'b1;
    if (wrap)     rd_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      gap_q      <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      gap_q      <= gap_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      to_err_q   <= to_err_d;
    end
  end

  assign rd_valid_o    = rd_valid_q;
  assign wr_ack_o      = wr_ack_q;
  assign timeout_err_o = to_err_q;
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Randomized scoreboard bench for rtc_bus_scheduler; the bench also plays both engines.
module tb_rtc_bus_scheduler;
  localparam int R   = 20;
  localparam int GAP = 4;
  localparam int TMO = 32;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_req = 1'b0, lect_fin = 1'b0, esc_fin = 1'b0;
  logic [4:0] lect_bus = '0, esc_bus = '0, rtc_bus;
  logic       lect_start, esc_start, rd_valid, wr_ack, busy, timeout_err;
  logic [2:0] state;

  rtc_bus_scheduler #(.REFRESH_CYCLES(R), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_i(rst_n), .wr_req_i(wr_req), .lect_fin_i(lect_fin),
    .lect_bus_i(lect_bus), .esc_fin_i(esc_fin), .esc_bus_i(esc_bus),
    .lect_start_o(lect_start), .esc_start_o(esc_start), .rtc_bus_o(rtc_bus),
    .rd_valid_o(rd_valid), .wr_ack_o(wr_ack), .busy_o(busy),
    .timeout_err_o(timeout_err), .state_o(state));

  always #5 clk = ~clk;

  // kinds: 0 lect_start, 1 esc_start, 2 rd_valid, 3 wr_ack, 4 timeout_err
  typedef struct {int cyc; int kind;} ev_t;
  ev_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  // Transaction-level reference: current access spans [m_s, m_f], gap follows, free again at m_free.
  int m_kind = 0, m_s = -100, m_f = -100, m_free = 0;
  bit m_to = 1'b0;
  int last_wr = -1, last_ws = 0, last_rs = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) if (run) cyc = cyc + 1;

  // Reference model + per-cycle bus/busy checks.
  always @(negedge clk) if (run) begin
    int c, wlast;
    bit wp, rp, in_acc, in_busy;
    logic [4:0] eb;
    c = cyc;
    in_acc  = (m_kind != 0) && (c >= m_s) && (c <= m_f);
    in_busy = (c >= m_s) && (c <= m_f + GAP);
    eb = 5'b11110;
    if (in_acc) eb = (m_kind == 2) ? esc_bus : lect_bus;
    chk("rtc_bus", int'(rtc_bus), int'(eb));
    chk("busy", int'(busy), int'(in_busy));
    if (!in_busy) chk("state_idle", int'(state), 0);
    else if (c == m_s) chk("state_start", int'(state), (m_kind == 2) ? 3 : 1);
    else if (c > m_f) chk("state_gap", int'(state), 5);
    if (c >= m_free) begin
      wp = (last_wr >= last_ws) && (last_wr < c);
      wlast = -1;
      if (c >= R) wlast = ((c - R) / R) * R + R - 1;
      rp = (wlast >= last_rs);
      if (wp || rp) begin
        m_kind = wp ? 2 : 1;
        m_s = c + 1;
        if (wp) last_ws = m_s; else last_rs = m_s;
        m_to = 1'b0;
        m_f = m_s + int'($urandom_range(1, 12));
`ifdef RTC_SCHED_TIMEOUT_EN
        case ($urandom_range(0, 7))
          0: m_to = 1'b1;
          1: m_f = m_s + TMO;
          default: ;
        endcase
        if (m_to) m_f = m_s + TMO;
`endif
        m_free = m_f + GAP + 1;
        exp_q.push_back('{m_s, wp ? 1 : 0});
        exp_q.push_back('{m_f + 1, m_to ? 4 : (wp ? 3 : 2)});
      end
    end
    if (wr_req) last_wr = c;
  end

  // Monitor: every output pulse must match the queue head, nothing expected may be skipped.
  always @(negedge clk) if (run) begin
    logic [4:0] p;
    p = {timeout_err, wr_ack, rd_valid, esc_start, lect_start};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_event kind=%0d got none required at cyc %0d", exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 5; k++) if (p[k]) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != k) begin
        errors++;
        $display("FAIL event got kind=%0d at cyc %0d required kind=%0d at cyc %0d", k, cyc,
                 (exp_q.size() > 0) ? exp_q[0].kind : -1, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
      end else void'(exp_q.pop_front());
    end
  end

  task automatic drive(input bit allow_wr);
    bit in_rd, in_wr;
    lect_bus = 5'($urandom);
    esc_bus  = 5'($urandom);
    in_rd = (m_kind == 1) && (cyc >= m_s) && (cyc <= m_f);
    in_wr = (m_kind == 2) && (cyc >= m_s) && (cyc <= m_f);
    wr_req = allow_wr && (($urandom_range(0, 29) == 0) ||
                          ((cyc % R == R - 1) && ($urandom_range(0, 3) == 0)));
    lect_fin = (m_kind == 1 && !m_to && cyc == m_f) || (!in_rd && $urandom_range(0, 9) == 0);
    esc_fin  = (m_kind == 2 && !m_to && cyc == m_f) || (!in_wr && $urandom_range(0, 9) == 0);
  endtask

  initial begin
    bit found;
    int guard;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", int'(rtc_bus), 30);
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({lect_start, esc_start, rd_valid, wr_ack, timeout_err}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1; cyc = 0; run = 1'b1;

    // Read-only refresh period first, then mixed traffic.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      drive(i > 150);
    end

    // Park mid-RD_BUSY, then yank reset asynchronously.
    found = 1'b0; guard = 0;
    while (!found && guard < 400) begin
      @(posedge clk); #1; guard++;
      if (m_kind == 1 && cyc > m_s && cyc + 1 < m_f) begin
        found = 1'b1;
        wr_req = 1'b0; lect_fin = 1'b0; esc_fin = 1'b0;
      end else drive(1'b0);
    end
    if (!found) chk("find_rd_busy", 0, 1);
    else begin
      chk("pre_rst_state", int'(state), 2);
      run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_bus", int'(rtc_bus), 30);
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      // Refresh restarts from zero: first lect_start in cycle R+1, nothing before it.
      for (int k = 0; k <= R + 1; k++) begin
        @(negedge clk);
        if (k <= R) begin
          chk("post_rst_quiet", int'({lect_start, esc_start, rd_valid, wr_ack, timeout_err}), 0);
          chk("post_rst_bus", int'(rtc_bus), 30);
        end else chk("post_rst_first_read", int'(lect_start), 1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
